cpu_controller: RTL and testbench

CPU_CONTROLLER -- requirements
Module: cpu_controller

---
 rtl/cpu_ctrl_pkg.sv | 48 ++++
 rtl/cpu_controller_decoder.sv | 48 ++++
 rtl/cpu_controller.sv | 193 +++++++++++++++++++
 tb/tb_cpu_controller.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the CPU controller: opcodes, FSM states, datapath mux selects.
// Also defines the decoded instruction classes handed from instr_decoder to cpu_controller.
package cpu_ctrl_pkg;

   localparam logic [4:0] OP_NOP      = 5'h00;
   localparam logic [4:0] OP_ALU_LAST = 5'h0F;
   localparam logic [4:0] OP_LDI      = 5'h10;
   localparam logic [4:0] OP_LD       = 5'h11;
   localparam logic [4:0] OP_ST       = 5'h12;
   localparam logic [4:0] OP_SSR      = 5'h13;
   localparam logic [4:0] OP_CALL     = 5'h14;
   localparam logic [4:0] OP_RET      = 5'h15;
   localparam logic [4:0] OP_BZ       = 5'h16;
   localparam logic [4:0] OP_OUTL     = 5'h17;
   localparam logic [4:0] OP_OUTH     = 5'h18;
   localparam logic [4:0] OP_INL      = 5'h19;
   localparam logic [4:0] OP_INH      = 5'h1A;
   localparam logic [4:0] OP_HALT     = 5'h1F;

   localparam int Z_BIT = 1;

   localparam logic [1:0] SEL1_REG = 2'd0;
   localparam logic [1:0] SEL1_PC  = 2'd1;
   localparam logic [1:0] SEL1_IMM = 2'd2;

   localparam logic [2:0] SEL2_ALU  = 3'd0;
   localparam logic [2:0] SEL2_INL  = 3'd1;
   localparam logic [2:0] SEL2_INH  = 3'd2;
   localparam logic [2:0] SEL2_BUS  = 3'd4;
   localparam logic [2:0] SEL2_LR   = 3'd5;
   localparam logic [2:0] SEL2_IMEM = 3'd6;
   localparam logic [2:0] SEL2_DMEM = 3'd7;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_LOADIR = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEMRD  = 3'd3,
      ST_CALL2  = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      CLS_NOP, CLS_ALU, CLS_LDI, CLS_LD, CLS_ST, CLS_SSR, CLS_CALL,
      CLS_RET, CLS_BZ, CLS_OUTL, CLS_OUTH, CLS_INL, CLS_INH, CLS_HALT
   } instr_class_t;

endpackage

// File: rtl/cpu_controller_decoder.sv
// Splits an instruction word into fields and an instruction class.
// Port I/O ops decode only when CPU_CONTROLLER_PORT_IO_EN is defined; otherwise they are NOPs.
module instr_decoder
   import cpu_ctrl_pkg::*;
(
   input  logic [15:0]  instr,
   output instr_class_t cls,
   output logic [4:0]   op,
   output logic [2:0]   rd,
   output logic [2:0]   rs,
   output logic [1:0]   fn
);

   logic unused_low;

   assign op = instr[15:11];
   assign rd = instr[10:8];
   assign rs = instr[7:5];
   assign fn = instr[4:3];
   // Low bits only matter as part of imm8, which the datapath takes straight from IR.
   assign unused_low = ^instr[2:0];

   always_comb begin
      cls = CLS_NOP;
      if (op != OP_NOP && op <= OP_ALU_LAST) begin
         cls = CLS_ALU;
      end else begin
         case (op)
            OP_LDI:  cls = CLS_LDI;
            OP_LD:   cls = CLS_LD;
            OP_ST:   cls = CLS_ST;
            OP_SSR:  cls = CLS_SSR;
            OP_CALL: cls = CLS_CALL;
            OP_RET:  cls = CLS_RET;
            OP_BZ:   cls = CLS_BZ;
`ifdef CPU_CONTROLLER_PORT_IO_EN
            OP_OUTL: cls = CLS_OUTL;
            OP_OUTH: cls = CLS_OUTH;
            OP_INL:  cls = CLS_INL;
            OP_INH:  cls = CLS_INH;
`endif
            OP_HALT: cls = CLS_HALT;
            default: cls = CLS_NOP;
         endcase
      end
   end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle CPU control FSM: fetch, IR load, execute, plus extra MEMRD/CALL2 steps and HALT.
// Optional port I/O instructions are enabled by CPU_CONTROLLER_PORT_IO_EN.
module cpu_controller
   import cpu_ctrl_pkg::*;
#(
   parameter int regFile_addrSize = 3,
   parameter int busSize          = 16,
   parameter int dataWordSize     = 8
) (
   input  logic                        clock,
   input  logic                        Rst,
   input  logic [busSize-1:0]          IROut,
   input  logic [dataWordSize-1:0]     StatusOut,
   input  logic [dataWordSize-1:0]     SROut,
   output logic [regFile_addrSize-1:0] a1,
   output logic [regFile_addrSize-1:0] a2,
   output logic [regFile_addrSize-1:0] aWrite,
   output logic                        loadReg,
   output logic                        selMuxDataReg,
   output logic                        incPC,
   output logic                        loadPCL,
   output logic                        loadPCH,
   output logic                        loadIRL,
   output logic                        loadIRH,
   output logic                        loadLR,
   output logic                        loadSR,
   output logic                        loadB2MB,
   output logic                        loadLEDL,
   output logic                        loadLEDH,
   output logic                        iWrite,
   output logic                        dWrite,
   output logic                        loadStatus,
   output logic [1:0]                  selMux1,
   output logic [2:0]                  selMux2,
   output logic [4:0]                  opcode,
   output logic [1:0]                  func,
   output logic                        halted
);

   state_t       state, state_next;
   instr_class_t cls;
   logic [4:0]   op;
   logic [2:0]   rd, rs;
   logic [1:0]   fn;
   logic         unused_inputs;

   instr_decoder u_decoder (
      .instr (IROut[15:0]),
      .cls   (cls),
      .op    (op),
      .rd    (rd),
      .rs    (rs),
      .fn    (fn)
   );

   // SROut feeds the data address in the datapath; only the Z flag steers control.
   assign unused_inputs = ^{SROut, StatusOut[dataWordSize-1:Z_BIT+1], StatusOut[Z_BIT-1:0]};

   always_ff @(posedge clock) begin
      if (Rst) state <= ST_FETCH;
      else     state <= state_next;
   end

   always_comb begin
      state_next    = state;
      a1            = '0;
      a2            = '0;
      aWrite        = '0;
      loadReg       = 1'b0;
      selMuxDataReg = 1'b0;
      incPC         = 1'b0;
      loadPCL       = 1'b0;
      loadPCH       = 1'b0;
      loadIRL       = 1'b0;
      loadIRH       = 1'b0;
      loadLR        = 1'b0;
      loadSR        = 1'b0;
      loadB2MB      = 1'b0;
      loadLEDL      = 1'b0;
      loadLEDH      = 1'b0;
      iWrite        = 1'b0;
      dWrite        = 1'b0;
      loadStatus    = 1'b0;
      selMux1       = SEL1_REG;
      selMux2       = SEL2_ALU;
      opcode        = '0;
      func          = '0;
      halted        = 1'b0;
      // Reset blanks every output, even before the first edge has forced FETCH.
      if (!Rst) begin
         case (state)
            ST_FETCH: state_next = ST_LOADIR;
            ST_LOADIR: begin
               selMux2    = SEL2_IMEM;
               loadIRH    = 1'b1;
               loadIRL    = 1'b1;
               incPC      = 1'b1;
               state_next = ST_EXEC;
            end
            ST_EXEC: begin
               state_next = ST_FETCH;
               case (cls)
                  CLS_ALU: begin
                     a1         = regFile_addrSize'(rd);
                     a2         = regFile_addrSize'(rs);
                     opcode     = op;
                     func       = fn;
                     aWrite     = regFile_addrSize'(rd);
                     loadReg    = 1'b1;
                     loadStatus = 1'b1;
                  end
                  CLS_LDI: begin
                     selMux1 = SEL1_IMM;
                     selMux2 = SEL2_BUS;
                     aWrite  = regFile_addrSize'(rd);
                     loadReg = 1'b1;
                  end
                  CLS_LD: state_next = ST_MEMRD;
                  CLS_ST: begin
                     a2     = regFile_addrSize'(rs);
                     dWrite = 1'b1;
                  end
                  CLS_SSR: begin
                     a2     = regFile_addrSize'(rs);
                     loadSR = 1'b1;
                  end
                  CLS_CALL: begin
                     selMux1    = SEL1_PC;
                     loadLR     = 1'b1;
                     state_next = ST_CALL2;
                  end
                  CLS_RET: begin
                     selMux2 = SEL2_LR;
                     loadPCL = 1'b1;
                     loadPCH = 1'b1;
                  end
                  CLS_BZ: begin
                     if (StatusOut[Z_BIT]) begin
                        selMux1 = SEL1_IMM;
                        selMux2 = SEL2_BUS;
                        loadPCL = 1'b1;
                        loadPCH = 1'b1;
                     end
                  end
`ifdef CPU_CONTROLLER_PORT_IO_EN
                  CLS_OUTL: begin
                     a2       = regFile_addrSize'(rs);
                     selMux2  = SEL2_BUS;
                     loadLEDL = 1'b1;
                  end
                  CLS_OUTH: begin
                     a2       = regFile_addrSize'(rs);
                     selMux2  = SEL2_BUS;
                     loadLEDH = 1'b1;
                  end
                  CLS_INL: begin
                     selMux2 = SEL2_INL;
                     aWrite  = regFile_addrSize'(rd);
                     loadReg = 1'b1;
                  end
                  CLS_INH: begin
                     selMux2 = SEL2_INH;
                     aWrite  = regFile_addrSize'(rd);
                     loadReg = 1'b1;
                  end
`endif
                  CLS_HALT: state_next = ST_HALT;
                  default: state_next = ST_FETCH;
               endcase
            end
            ST_MEMRD: begin
               selMux2    = SEL2_DMEM;
               aWrite     = regFile_addrSize'(rd);
               loadReg    = 1'b1;
               state_next = ST_FETCH;
            end
            ST_CALL2: begin
               selMux1    = SEL1_IMM;
               selMux2    = SEL2_BUS;
               loadPCL    = 1'b1;
               loadPCH    = 1'b1;
               state_next = ST_FETCH;
            end
            ST_HALT: begin
               halted     = 1'b1;
               state_next = ST_HALT;
            end
            default: state_next = ST_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: per-cycle expected outputs from an opcode rule table
// are queued by the stimulus process and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_cpu_controller;

   logic        clock = 1'b0;
   logic        Rst;
   logic [15:0] IROut;
   logic [7:0]  StatusOut, SROut;
   logic [2:0]  a1, a2, aWrite;
   logic        loadReg, selMuxDataReg, incPC, loadPCL, loadPCH, loadIRL, loadIRH;
   logic        loadLR, loadSR, loadB2MB, loadLEDL, loadLEDH, iWrite, dWrite, loadStatus;
   logic [1:0]  selMux1;
   logic [2:0]  selMux2;
   logic [4:0]  opcode;
   logic [1:0]  func;
   logic        halted;

   always #5 clock = ~clock;

   cpu_controller #(.regFile_addrSize(3), .busSize(16), .dataWordSize(8)) dut (
      .clock(clock), .Rst(Rst), .IROut(IROut), .StatusOut(StatusOut), .SROut(SROut),
      .a1(a1), .a2(a2), .aWrite(aWrite), .loadReg(loadReg), .selMuxDataReg(selMuxDataReg),
      .incPC(incPC), .loadPCL(loadPCL), .loadPCH(loadPCH), .loadIRL(loadIRL),
      .loadIRH(loadIRH), .loadLR(loadLR), .loadSR(loadSR), .loadB2MB(loadB2MB),
      .loadLEDL(loadLEDL), .loadLEDH(loadLEDH), .iWrite(iWrite), .dWrite(dWrite),
      .loadStatus(loadStatus), .selMux1(selMux1), .selMux2(selMux2), .opcode(opcode),
      .func(func), .halted(halted)
   );

   typedef struct packed {
      logic [2:0] a1, a2, aWrite;
      logic       loadReg, selMuxDataReg, incPC, loadPCL, loadPCH, loadIRL, loadIRH;
      logic       loadLR, loadSR, loadB2MB, loadLEDL, loadLEDH, iWrite, dWrite, loadStatus;
      logic [1:0] selMux1;
      logic [2:0] selMux2;
      logic [4:0] opcode;
      logic [1:0] func;
      logic       halted;
   } vec_t;

   vec_t exp_q[$];
   vec_t seq[$];
   vec_t act, zero_v, halt_v;
   int   vectors = 0;
   int   miscompares = 0;
   int   cycle = 0;

   assign act = {a1, a2, aWrite, loadReg, selMuxDataReg, incPC, loadPCL, loadPCH, loadIRL,
                 loadIRH, loadLR, loadSR, loadB2MB, loadLEDL, loadLEDH, iWrite, dWrite,
                 loadStatus, selMux1, selMux2, opcode, func, halted};

   always @(posedge clock) cycle <= cycle + 1;

   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         vec_t e;
         e = exp_q.pop_front();
         vectors++;
         if (act !== e) begin
            miscompares++;
            $display("FAIL outputs cycle=%0d ir=%h st=%h rst=%b got=%h want=%h",
                     cycle, IROut, StatusOut, Rst, act, e);
         end
      end
   end

   // Expected per-cycle outputs of one instruction: fetch, IR load, execute, optional 4th step.
   task automatic build_seq(input logic [15:0] ir, input logic [7:0] st);
      logic [4:0] op;
      logic [2:0] rd, rs;
      logic [1:0] fn;
      vec_t ld, ex, ex2;
      bit   four;
      op = ir[15:11]; rd = ir[10:8]; rs = ir[7:5]; fn = ir[4:3];
      ld = '0; ld.loadIRH = 1; ld.loadIRL = 1; ld.incPC = 1; ld.selMux2 = 3'd6;
      ex = '0; ex2 = '0; four = 0;
      if (op >= 5'd1 && op <= 5'd15) begin
         ex.a1 = rd; ex.a2 = rs; ex.opcode = op; ex.func = fn;
         ex.aWrite = rd; ex.loadReg = 1; ex.loadStatus = 1;
      end else begin
         case (op)
            5'h10: begin ex.selMux1 = 2; ex.selMux2 = 4; ex.aWrite = rd; ex.loadReg = 1; end
            5'h11: begin four = 1; ex2.selMux2 = 7; ex2.aWrite = rd; ex2.loadReg = 1; end
            5'h12: begin ex.a2 = rs; ex.dWrite = 1; end
            5'h13: begin ex.a2 = rs; ex.loadSR = 1; end
            5'h14: begin
               four = 1; ex.selMux1 = 1; ex.loadLR = 1;
               ex2.selMux1 = 2; ex2.selMux2 = 4; ex2.loadPCL = 1; ex2.loadPCH = 1;
            end
            5'h15: begin ex.selMux2 = 5; ex.loadPCL = 1; ex.loadPCH = 1; end
            5'h16: if (st[1]) begin
               ex.selMux1 = 2; ex.selMux2 = 4; ex.loadPCL = 1; ex.loadPCH = 1;
            end
`ifdef CPU_CONTROLLER_PORT_IO_EN
            5'h17: begin ex.a2 = rs; ex.selMux2 = 4; ex.loadLEDL = 1; end
            5'h18: begin ex.a2 = rs; ex.selMux2 = 4; ex.loadLEDH = 1; end
            5'h19: begin ex.selMux2 = 1; ex.aWrite = rd; ex.loadReg = 1; end
            5'h1A: begin ex.selMux2 = 2; ex.aWrite = rd; ex.loadReg = 1; end
`endif
            default: ;
         endcase
      end
      seq.delete();
      seq.push_back(zero_v);
      seq.push_back(ld);
      seq.push_back(ex);
      if (four) seq.push_back(ex2);
   endtask

   // Called right after a clock edge with the controller in FETCH; returns in the same position.
   task automatic run_instr(input logic [15:0] ir, input logic [7:0] st, input int rst_at);
      build_seq(ir, st);
      IROut = ir; StatusOut = st; SROut = 8'($urandom);
      for (int i = 0; i < seq.size(); i++) begin
         if (i == rst_at) begin
            Rst = 1'b1;
            exp_q.push_back(zero_v);
            @(posedge clock); #1;
            Rst = 1'b0;
            return;
         end
         exp_q.push_back(seq[i]);
         @(posedge clock); #1;
      end
      if (ir[15:11] == 5'h1F) begin
         for (int j = 0; j < 10; j++) begin
            exp_q.push_back(halt_v);
            @(posedge clock); #1;
            IROut = 16'($urandom); StatusOut = 8'($urandom);
         end
         Rst = 1'b1;
         exp_q.push_back(zero_v);
         @(posedge clock); #1;
         Rst = 1'b0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      zero_v = '0;
      halt_v = '0; halt_v.halted = 1'b1;
      Rst = 1'b1; IROut = 16'h0000; StatusOut = 8'h00; SROut = 8'h00;
      repeat (3) begin
         @(posedge clock); #1;
         IROut = 16'($urandom);
         exp_q.push_back(zero_v);
      end
      @(posedge clock); #1;
      Rst = 1'b0;

      run_instr(16'h8000, 8'h00, -1);
      run_instr(16'h0B48, 8'h00, -1);
      run_instr(16'h8A10, 8'h00, -1);
      run_instr(16'hB040, 8'h02, -1);
      run_instr(16'hB040, 8'h00, -1);
      run_instr(16'hB860, 8'h00, -1);
      run_instr(16'hA055, 8'h00, -1);
      run_instr(16'h8A10, 8'h00, 3);
      run_instr(16'hA055, 8'h00, 3);
      run_instr(16'h0B48, 8'h00, 2);
      run_instr(16'hF800, 8'h00, -1);
      run_instr(16'hF800, 8'h00, 2);
      run_instr(16'h0000, 8'hFF, -1);

      for (int n = 0; n < 400; n++) begin
         logic [15:0] ir;
         logic [7:0]  st;
         int          ra;
         ir = 16'($urandom);
         st = 8'($urandom);
         ra = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 3)) : -1;
         run_instr(ir, st, ra);
      end

      repeat (2) @(posedge clock);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL queue_drain got=%0d want=0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
